addsub_pipe: RTL

ADDSUB_PIPE -- requirements
Module: addsub_pipe

---
 rtl/addsub_pipe.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/addsub_pipe.sv
// -----------------------------------------------------------------------------
// addsub_pipe
//
// Two-stage pipelined two's-complement adder/subtractor with an internal
// accumulator, optional saturation on signed overflow and a sticky overflow
// flag. Valid/ready handshaking on both sides. Stage S1 holds the raw operands
// and mode. Stage S2 holds the computed result and flags.
//
// Parameters
//   WIDTH      operand/result width in bits (2..64)
//   SAT        0 = wrap on signed overflow, 1 = saturate on signed overflow
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operand beat offered
//   in_ready   block accepts the beat this cycle (combinational)
//   op1, op2   two's-complement operands
//   mode       00 add, 01 sub, 10 acc+op1, 11 load acc<=op1
//   clr_sticky one-cycle pulse clearing of_sticky
//   out_valid  result beat available
//   out_ready  downstream accepts the result beat
//   result     registered result
//   ofFlag     signed overflow of the current result beat
//   carry      unsigned carry-out (add/acc) or no-borrow (sub)
//   of_sticky  latched overflow indication
//   acc        current accumulator value
// -----------------------------------------------------------------------------
module addsub_pipe #(
    parameter int WIDTH = 8,
    parameter bit SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [1:0]       mode,
    input  logic             clr_sticky,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ofFlag,
    output logic             carry,
    output logic             of_sticky,
    output logic [WIDTH-1:0] acc
);

    localparam logic [1:0] MODE_ADD  = 2'b00;
    localparam logic [1:0] MODE_SUB  = 2'b01;
    localparam logic [1:0] MODE_ACC  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Saturation bound selected by the sign of the first operand.
    function automatic logic [WIDTH-1:0] sat_value(input logic neg);
        logic [WIDTH-1:0] v;
        if (neg) begin
            v = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            v = {1'b0, {(WIDTH-1){1'b1}}};
        end
        return v;
    endfunction

    // Stage S1 state
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_op1_q,   s1_op1_d;
    logic [WIDTH-1:0] s1_op2_q,   s1_op2_d;
    logic [1:0]       s1_mode_q,  s1_mode_d;

    // Stage S2 state
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] result_q,   result_d;
    logic             of_q,       of_d;
    logic             carry_q,    carry_d;

    // Architectural state
    logic [WIDTH-1:0] acc_q,      acc_d;
    logic             sticky_q,   sticky_d;

    // Handshake and datapath intermediates
    logic             s2_advance;
    logic             s1_move;
    logic             accept;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             cin;
    logic [WIDTH:0]   raw_sum;
    logic [WIDTH-1:0] raw_res;
    logic [WIDTH-1:0] fin_res;
    logic             calc_of;
    logic             calc_carry;

    // Pipeline flow control: S2 drains or is empty, S1 follows S2.
    always_comb begin
        s2_advance = !s2_valid_q || out_ready;
        s1_move    = s1_valid_q && s2_advance;
        in_ready   = !s1_valid_q || s2_advance;
        accept     = in_valid && in_ready;
    end

    // Arithmetic on the S1 beat. Subtraction is op1 + ~op2 + 1, so the
    // overflow rule "both addend signs equal, result sign differs" covers
    // add, sub and accumulate alike once opb is the effective addend.
    always_comb begin
        opa = s1_op1_q;
        opb = s1_op2_q;
        cin = 1'b0;
        case (s1_mode_q)
            MODE_ADD: begin
                opa = s1_op1_q;
                opb = s1_op2_q;
                cin = 1'b0;
            end
            MODE_SUB: begin
                opa = s1_op1_q;
                opb = ~s1_op2_q;
                cin = 1'b1;
            end
            MODE_ACC: begin
                opa = acc_q;
                opb = s1_op1_q;
                cin = 1'b0;
            end
            MODE_LOAD: begin
                opa = s1_op1_q;
                opb = {WIDTH{1'b0}};
                cin = 1'b0;
            end
            default: begin
                opa = s1_op1_q;
                opb = s1_op2_q;
                cin = 1'b0;
            end
        endcase

        raw_sum = {1'b0, opa} + {1'b0, opb} + {{WIDTH{1'b0}}, cin};
        raw_res = raw_sum[WIDTH-1:0];

        if (s1_mode_q == MODE_LOAD) begin
            calc_of    = 1'b0;
            calc_carry = 1'b0;
            fin_res    = s1_op1_q;
        end else begin
            calc_of    = (opa[WIDTH-1] == opb[WIDTH-1]) && (raw_res[WIDTH-1] != opa[WIDTH-1]);
            calc_carry = raw_sum[WIDTH];
            if (SAT && calc_of) begin
                fin_res = sat_value(opa[WIDTH-1]);
            end else begin
                fin_res = raw_res;
            end
        end
    end

    // Next-state for both stages, the accumulator and the sticky flag.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op1_d   = s1_op1_q;
        s1_op2_d   = s1_op2_q;
        s1_mode_d  = s1_mode_q;
        s2_valid_d = s2_valid_q;
        result_d   = result_q;
        of_d       = of_q;
        carry_d    = carry_q;
        acc_d      = acc_q;
        sticky_d   = sticky_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_op1_d   = op1;
            s1_op2_d   = op2;
            s1_mode_d  = mode;
        end else if (s1_move) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end

        // Result fields only change when a new beat arrives, so they stay
        // stable under backpressure and after the last beat drains.
        if (s2_advance) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                result_d = fin_res;
                of_d     = calc_of;
                carry_d  = calc_carry;
            end else begin
                result_d = result_q;
                of_d     = of_q;
                carry_d  = carry_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end

        // acc updates as its beat enters S2, so the next S1 beat already
        // sees the new value on the following cycle.
        if (s1_move && s1_mode_q[1]) begin
            acc_d = fin_res;
        end else begin
            acc_d = acc_q;
        end

        // A new overflow beats a simultaneous clear.
        if (s1_move && calc_of) begin
            sticky_d = 1'b1;
        end else if (clr_sticky) begin
            sticky_d = 1'b0;
        end else begin
            sticky_d = sticky_q;
        end
    end

    // State registers with synchronous reset discarding in-flight beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_op1_q   <= {WIDTH{1'b0}};
            s1_op2_q   <= {WIDTH{1'b0}};
            s1_mode_q  <= 2'b00;
            s2_valid_q <= 1'b0;
            result_q   <= {WIDTH{1'b0}};
            of_q       <= 1'b0;
            carry_q    <= 1'b0;
            acc_q      <= {WIDTH{1'b0}};
            sticky_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op1_q   <= s1_op1_d;
            s1_op2_q   <= s1_op2_d;
            s1_mode_q  <= s1_mode_d;
            s2_valid_q <= s2_valid_d;
            result_q   <= result_d;
            of_q       <= of_d;
            carry_q    <= carry_d;
            acc_q      <= acc_d;
            sticky_q   <= sticky_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign result    = result_q;
    assign ofFlag    = of_q;
    assign carry     = carry_q;
    assign of_sticky = sticky_q;
    assign acc       = acc_q;

endmodule
